// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for the decode queue.
// The decode stage takes the slave view; whoever drives fetch/execute takes master.
interface decode_queue_if #(
   parameter int IW    = 16,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          flush_in;
   logic          inst_valid_in;
   logic [IW-1:0] inst_in;
   logic [IW-1:0] pc_in;
   logic          inst_ready_out;
   logic          dec_valid_out;
   logic          dec_ready_in;
   logic [IW-1:0] dec_pc_out;
   logic [4:0]    dec_opcode_out;
   logic [3:0]    dec_class_out;
   logic [2:0]    dec_rs_out;
   logic [2:0]    dec_rt_out;
   logic [2:0]    dec_rd_out;
   logic          dec_wr_en_out;
   logic [IW-1:0] dec_imm_out;
   logic          halted_out;
   logic [CW-1:0] count_out;

   modport slave (
      input  flush_in, inst_valid_in, inst_in, pc_in, dec_ready_in,
      output inst_ready_out, dec_valid_out, dec_pc_out, dec_opcode_out,
             dec_class_out, dec_rs_out, dec_rt_out, dec_rd_out,
             dec_wr_en_out, dec_imm_out, halted_out, count_out
   );

   modport master (
      output flush_in, inst_valid_in, inst_in, pc_in, dec_ready_in,
      input  inst_ready_out, dec_valid_out, dec_pc_out, dec_opcode_out,
             dec_class_out, dec_rs_out, dec_rt_out, dec_rd_out,
             dec_wr_en_out, dec_imm_out, halted_out, count_out
   );
endinterface

// File: rtl/decode_queue.sv
// Buffered decode stage: FIFO of fetched instruction/PC pairs, a combinational
// decoder on the FIFO head, and one registered uop slot toward execute.
// A HALT uop drains the stage and parks it until reset or flush.
module decode_queue #(
   parameter int IW    = 16,
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   decode_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [3:0] C_NOP     = 4'd0;
   localparam logic [3:0] C_JDISP   = 4'd1;
   localparam logic [3:0] C_JREG    = 4'd2;
   localparam logic [3:0] C_ALUI    = 4'd3;
   localparam logic [3:0] C_BRANCH  = 4'd4;
   localparam logic [3:0] C_MEM     = 4'd5;
   localparam logic [3:0] C_SLBI    = 4'd6;
   localparam logic [3:0] C_SHIFTI  = 4'd7;
   localparam logic [3:0] C_LBI     = 4'd8;
   localparam logic [3:0] C_BTR     = 4'd9;
   localparam logic [3:0] C_ALURR   = 4'd10;
   localparam logic [3:0] C_SHIFTRR = 4'd11;
   localparam logic [3:0] C_CMP     = 4'd12;
   localparam logic [3:0] C_HALT    = 4'd13;
   localparam logic [3:0] C_ILLEGAL = 4'd14;
   localparam logic [3:0] C_RTI     = 4'd15;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t        state, state_next;
   logic [IW-1:0] inst_mem [DEPTH];
   logic [IW-1:0] pc_mem   [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic          slot_valid;
   logic [IW-1:0] slot_pc, slot_imm;
   logic [4:0]    slot_opcode;
   logic [3:0]    slot_class;
   logic [2:0]    slot_rs, slot_rt, slot_rd;
   logic          slot_wr_en;

   logic [IW-1:0] head_inst, head_pc, head_imm;
   logic [4:0]    head_op;
   logic [3:0]    head_class;
   logic [2:0]    head_rd;
   logic          head_wr_en;
   logic          ready, push, load;

   assign head_inst = inst_mem[rd_ptr];
   assign head_pc   = pc_mem[rd_ptr];
   assign head_op   = head_inst[15:11];

   // Ready comes only from registered state so execute backpressure never reaches fetch.
   assign ready = (state == RUN) && (count < CW'(DEPTH));
   assign push  = bus.inst_valid_in && ready && !bus.flush_in;
   assign load  = (count != '0) && (state == RUN) && !bus.flush_in &&
                  (!slot_valid || bus.dec_ready_in);

   // Decode the FIFO head: class first, then destination and immediate from the class.
   always_comb begin
      head_class = C_NOP;
      head_rd    = 3'd0;
      head_wr_en = 1'b0;
      head_imm   = '0;
      casez (head_op)
         5'b00000: head_class = C_HALT;
         5'b00001: head_class = C_NOP;
         5'b00010: head_class = C_ILLEGAL;
         5'b00011: head_class = C_RTI;
         5'b001?0: head_class = C_JDISP;
         5'b001?1: head_class = C_JREG;
         5'b010??: head_class = C_ALUI;
         5'b011??: head_class = C_BRANCH;
         5'b10000: head_class = C_MEM;
         5'b10001: head_class = C_MEM;
         5'b10010: head_class = C_SLBI;
         5'b10011: head_class = C_MEM;
         5'b101??: head_class = C_SHIFTI;
         5'b11000: head_class = C_LBI;
         5'b11001: head_class = C_BTR;
         5'b11010: head_class = C_SHIFTRR;
         5'b11011: head_class = C_ALURR;
         5'b111??: head_class = C_CMP;
         default:  head_class = C_NOP;
      endcase
      case (head_class)
         C_ALUI, C_SHIFTI: begin
            head_rd    = head_inst[7:5];
            head_wr_en = 1'b1;
         end
         C_MEM: begin
            if (head_op != 5'b10000) begin
               head_rd    = head_inst[7:5];
               head_wr_en = 1'b1;
            end
         end
         C_BTR, C_ALURR, C_SHIFTRR, C_CMP: begin
            head_rd    = head_inst[4:2];
            head_wr_en = 1'b1;
         end
         C_SLBI, C_LBI: begin
            head_rd    = head_inst[10:8];
            head_wr_en = 1'b1;
         end
         C_JDISP, C_JREG: begin
            if (head_op[1]) begin
               head_rd    = 3'd7;
               head_wr_en = 1'b1;
            end
         end
         default: ;
      endcase
      case (head_class)
         C_JDISP:                 head_imm = {{(IW-11){head_inst[10]}}, head_inst[10:0]};
         C_JREG, C_BRANCH, C_LBI: head_imm = {{(IW-8){head_inst[7]}}, head_inst[7:0]};
         C_SLBI:                  head_imm = {{(IW-8){1'b0}}, head_inst[7:0]};
         C_SHIFTI:                head_imm = {{(IW-5){1'b0}}, head_inst[4:0]};
         C_ALUI:                  head_imm = head_op[1] ? {{(IW-5){1'b0}}, head_inst[4:0]}
                                                        : {{(IW-5){head_inst[4]}}, head_inst[4:0]};
         C_MEM:                   head_imm = {{(IW-5){head_inst[4]}}, head_inst[4:0]};
         default:                 head_imm = '0;
      endcase
   end

   // Halt sequencing: a HALT entering the slot stops the FIFO, its acceptance parks the stage.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (load && head_class == C_HALT) state_next = DRAIN;
         DRAIN:   if (slot_valid && bus.dec_ready_in) state_next = HALTED;
         HALTED:  state_next = HALTED;
         default: state_next = RUN;
      endcase
   end

   // State register; flush overrides any transition and returns to RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               state <= RUN;
      else if (bus.flush_in) state <= RUN;
      else                   state <= state_next;
   end

   // FIFO storage is not reset; occupancy and pointers decide what is meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= bus.inst_in;
         pc_mem[wr_ptr]   <= bus.pc_in;
      end
   end

   // Pointers and occupancy; a slot load is the FIFO pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (load) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(load);
      end
   end

   // Output slot: load the decoded head, or empty it once execute takes the uop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid  <= 1'b0;
         slot_pc     <= '0;
         slot_opcode <= 5'd0;
         slot_class  <= 4'd0;
         slot_rs     <= 3'd0;
         slot_rt     <= 3'd0;
         slot_rd     <= 3'd0;
         slot_wr_en  <= 1'b0;
         slot_imm    <= '0;
      end else if (bus.flush_in) begin
         slot_valid <= 1'b0;
      end else if (load) begin
         slot_valid  <= 1'b1;
         slot_pc     <= head_pc;
         slot_opcode <= head_op;
         slot_class  <= head_class;
         slot_rs     <= head_inst[10:8];
         slot_rt     <= head_inst[7:5];
         slot_rd     <= head_rd;
         slot_wr_en  <= head_wr_en;
         slot_imm    <= head_imm;
      end else if (slot_valid && bus.dec_ready_in) begin
         slot_valid <= 1'b0;
      end
   end

   assign bus.inst_ready_out = ready;
   assign bus.dec_valid_out  = slot_valid;
   assign bus.dec_pc_out     = slot_pc;
   assign bus.dec_opcode_out = slot_opcode;
   assign bus.dec_class_out  = slot_class;
   assign bus.dec_rs_out     = slot_rs;
   assign bus.dec_rt_out     = slot_rt;
   assign bus.dec_rd_out     = slot_rd;
   assign bus.dec_wr_en_out  = slot_wr_en;
   assign bus.dec_imm_out    = slot_imm;
   assign bus.halted_out     = (state == HALTED);
   assign bus.count_out      = count;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO fill/drain, halt, flush, reset.
module tb_decode_queue;
   localparam int IW    = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   decode_queue_if #(.IW(IW), .DEPTH(DEPTH)) bus ();

   decode_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [15:0] inst, input logic [15:0] pc);
      bus.inst_valid_in = 1'b1;
      bus.inst_in       = inst;
      bus.pc_in         = pc;
      step();
      bus.inst_valid_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.flush_in = 1'b0; bus.inst_valid_in = 1'b0; bus.inst_in = '0; bus.pc_in = '0; bus.dec_ready_in = 1'b0;
      repeat (2) step();
      checks++; if (bus.inst_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", bus.inst_ready_out); end
      checks++; if (bus.dec_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.dec_valid_out); end
      checks++; if (bus.halted_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b want 0", bus.halted_out); end
      checks++; if (bus.count_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count_out); end
      checks++; if (bus.dec_pc_out !== 16'h0 || bus.dec_imm_out !== 16'h0 || bus.dec_class_out !== 4'd0) begin errors++; $display("[TB] FAIL reset_data: got pc %h imm %h class %0d want 0", bus.dec_pc_out, bus.dec_imm_out, bus.dec_class_out); end
      rst = 1'b0;
   endtask

   task automatic test_add_decode();
      bus.dec_ready_in = 1'b0;
      push_one(16'hD8A0, 16'h0010);
      checks++; if (bus.dec_valid_out !== 1'b0 || bus.count_out !== 3'd1) begin errors++; $display("[TB] FAIL add_after_push: got valid %b count %0d want 0/1", bus.dec_valid_out, bus.count_out); end
      step();
      checks++; if (bus.dec_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %b want 1", bus.dec_valid_out); end
      checks++; if (bus.dec_class_out !== 4'd10) begin errors++; $display("[TB] FAIL add_class: got %0d want 10", bus.dec_class_out); end
      checks++; if (bus.dec_opcode_out !== 5'b11011) begin errors++; $display("[TB] FAIL add_opcode: got %b want 11011", bus.dec_opcode_out); end
      checks++; if (bus.dec_rs_out !== 3'd0 || bus.dec_rt_out !== 3'd5) begin errors++; $display("[TB] FAIL add_rs_rt: got %0d/%0d want 0/5", bus.dec_rs_out, bus.dec_rt_out); end
      checks++; if (bus.dec_rd_out !== 3'd0 || bus.dec_wr_en_out !== 1'b1) begin errors++; $display("[TB] FAIL add_rd: got rd %0d wr %b want 0/1", bus.dec_rd_out, bus.dec_wr_en_out); end
      checks++; if (bus.dec_pc_out !== 16'h0010) begin errors++; $display("[TB] FAIL add_pc: got %h want 0010", bus.dec_pc_out); end
      bus.dec_ready_in = 1'b1;
      step();
      checks++; if (bus.dec_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL add_consumed: got valid %b want 0", bus.dec_valid_out); end
      bus.dec_ready_in = 1'b0;
   endtask

   task automatic test_immediates();
      logic [15:0] t_inst  [9] = '{16'h4B3F, 16'h533F, 16'h2400, 16'h3001, 16'hC0F0, 16'h92F0, 16'h803F, 16'h6A85, 16'hA5E9};
      logic [3:0]  t_class [9] = '{4'd3, 4'd3, 4'd1, 4'd1, 4'd8, 4'd6, 4'd5, 4'd4, 4'd7};
      logic [2:0]  t_rd    [9] = '{3'd1, 3'd1, 3'd0, 3'd7, 3'd0, 3'd2, 3'd0, 3'd0, 3'd7};
      logic        t_wr    [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] t_imm   [9] = '{16'hFFFF, 16'h001F, 16'hFC00, 16'h0001, 16'hFFF0, 16'h00F0, 16'hFFFF, 16'hFF85, 16'h0009};
      for (int i = 0; i < 9; i++) begin
         push_one(t_inst[i], 16'h0020 + 16'(i));
         step();
         checks++; if (bus.dec_valid_out !== 1'b1 || bus.dec_class_out !== t_class[i]) begin errors++; $display("[TB] FAIL imm_class[%0d]: got valid %b class %0d want 1/%0d", i, bus.dec_valid_out, bus.dec_class_out, t_class[i]); end
         checks++; if (bus.dec_rd_out !== t_rd[i] || bus.dec_wr_en_out !== t_wr[i]) begin errors++; $display("[TB] FAIL imm_rd[%0d]: got rd %0d wr %b want %0d/%b", i, bus.dec_rd_out, bus.dec_wr_en_out, t_rd[i], t_wr[i]); end
         checks++; if (bus.dec_imm_out !== t_imm[i]) begin errors++; $display("[TB] FAIL imm_value[%0d]: got %h want %h", i, bus.dec_imm_out, t_imm[i]); end
         bus.dec_ready_in = 1'b1;
         step();
         bus.dec_ready_in = 1'b0;
      end
   endtask

   task automatic test_full();
      bus.dec_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.inst_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b want 1", i, bus.inst_ready_out); end
         push_one(16'h0800, 16'h0100 + 16'(i));
      end
      checks++; if (bus.count_out !== 3'd4 || bus.inst_ready_out !== 1'b0) begin errors++; $display("[TB] FAIL full_state: got count %0d ready %b want 4/0", bus.count_out, bus.inst_ready_out); end
      checks++; if (bus.dec_valid_out !== 1'b1 || bus.dec_pc_out !== 16'h0100) begin errors++; $display("[TB] FAIL full_slot: got valid %b pc %h want 1/0100", bus.dec_valid_out, bus.dec_pc_out); end
      step();
      checks++; if (bus.dec_pc_out !== 16'h0100 || bus.count_out !== 3'd4) begin errors++; $display("[TB] FAIL stall_hold: got pc %h count %0d want 0100/4", bus.dec_pc_out, bus.count_out); end
      bus.dec_ready_in  = 1'b1;
      bus.inst_valid_in = 1'b1; bus.inst_in = 16'h0800; bus.pc_in = 16'h0105;
      checks++; if (bus.inst_ready_out !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_ready: got %b want 0", bus.inst_ready_out); end
      step();
      checks++; if (bus.count_out !== 3'd3 || bus.dec_pc_out !== 16'h0101 || bus.inst_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL drain_1: got count %0d pc %h ready %b want 3/0101/1", bus.count_out, bus.dec_pc_out, bus.inst_ready_out); end
      step();
      checks++; if (bus.count_out !== 3'd3 || bus.dec_pc_out !== 16'h0102) begin errors++; $display("[TB] FAIL push_pop_at_3: got count %0d pc %h want 3/0102", bus.count_out, bus.dec_pc_out); end
      bus.inst_valid_in = 1'b0;
      for (int i = 3; i < 6; i++) begin
         step();
         checks++; if (bus.dec_valid_out !== 1'b1 || bus.dec_pc_out !== 16'h0100 + 16'(i) || bus.count_out !== 3'(5 - i)) begin errors++; $display("[TB] FAIL drain_order[%0d]: got valid %b pc %h count %0d want 1/%h/%0d", i, bus.dec_valid_out, bus.dec_pc_out, bus.count_out, 16'h0100 + 16'(i), 5 - i); end
      end
      step();
      checks++; if (bus.dec_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got valid %b want 0", bus.dec_valid_out); end
      bus.dec_ready_in = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus.dec_ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.inst_valid_in = 1'b1; bus.inst_in = 16'h0800; bus.pc_in = 16'h0200 + 16'(i);
         step();
         if (i >= 1) begin
            checks++; if (bus.dec_valid_out !== 1'b1 || bus.dec_pc_out !== 16'h0200 + 16'(i - 1) || bus.count_out !== 3'd1) begin errors++; $display("[TB] FAIL b2b[%0d]: got valid %b pc %h count %0d want 1/%h/1", i, bus.dec_valid_out, bus.dec_pc_out, bus.count_out, 16'h0200 + 16'(i - 1)); end
         end
      end
      bus.inst_valid_in = 1'b0;
      step();
      checks++; if (bus.dec_pc_out !== 16'h0205 || bus.count_out !== 3'd0) begin errors++; $display("[TB] FAIL b2b_last: got pc %h count %0d want 0205/0", bus.dec_pc_out, bus.count_out); end
      step();
      checks++; if (bus.dec_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got valid %b want 0", bus.dec_valid_out); end
      bus.dec_ready_in = 1'b0;
   endtask

   task automatic test_halt();
      bus.dec_ready_in = 1'b0;
      push_one(16'h0800, 16'h0300);
      push_one(16'h0000, 16'h0301);
      push_one(16'hD8A0, 16'h0302);
      checks++; if (bus.dec_pc_out !== 16'h0300 || bus.count_out !== 3'd2) begin errors++; $display("[TB] FAIL halt_pre: got pc %h count %0d want 0300/2", bus.dec_pc_out, bus.count_out); end
      bus.dec_ready_in = 1'b1;
      step();
      bus.dec_ready_in = 1'b0;
      checks++; if (bus.dec_class_out !== 4'd13 || bus.dec_valid_out !== 1'b1 || bus.dec_pc_out !== 16'h0301) begin errors++; $display("[TB] FAIL halt_slot: got class %0d valid %b pc %h want 13/1/0301", bus.dec_class_out, bus.dec_valid_out, bus.dec_pc_out); end
      checks++; if (bus.inst_ready_out !== 1'b0 || bus.count_out !== 3'd1 || bus.halted_out !== 1'b0) begin errors++; $display("[TB] FAIL halt_drain: got ready %b count %0d halted %b want 0/1/0", bus.inst_ready_out, bus.count_out, bus.halted_out); end
      step();
      checks++; if (bus.dec_class_out !== 4'd13 || bus.dec_valid_out !== 1'b1 || bus.count_out !== 3'd1) begin errors++; $display("[TB] FAIL halt_hold: got class %0d valid %b count %0d want 13/1/1", bus.dec_class_out, bus.dec_valid_out, bus.count_out); end
      bus.dec_ready_in = 1'b1;
      step();
      checks++; if (bus.halted_out !== 1'b1 || bus.dec_valid_out !== 1'b0 || bus.inst_ready_out !== 1'b0) begin errors++; $display("[TB] FAIL halted: got halted %b valid %b ready %b want 1/0/0", bus.halted_out, bus.dec_valid_out, bus.inst_ready_out); end
      step();
      checks++; if (bus.halted_out !== 1'b1 || bus.dec_valid_out !== 1'b0 || bus.count_out !== 3'd1) begin errors++; $display("[TB] FAIL halted_park: got halted %b valid %b count %0d want 1/0/1", bus.halted_out, bus.dec_valid_out, bus.count_out); end
      bus.dec_ready_in = 1'b0;
      bus.flush_in = 1'b1;
      step();
      bus.flush_in = 1'b0;
      checks++; if (bus.halted_out !== 1'b0 || bus.count_out !== 3'd0 || bus.inst_ready_out !== 1'b1 || bus.dec_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL halt_flush: got halted %b count %0d ready %b valid %b want 0/0/1/0", bus.halted_out, bus.count_out, bus.inst_ready_out, bus.dec_valid_out); end
   endtask

   task automatic test_flush();
      bus.dec_ready_in = 1'b0;
      push_one(16'hD8A0, 16'h0400);
      push_one(16'hD8A0, 16'h0401);
      checks++; if (bus.dec_valid_out !== 1'b1 || bus.count_out !== 3'd1) begin errors++; $display("[TB] FAIL flush_pre: got valid %b count %0d want 1/1", bus.dec_valid_out, bus.count_out); end
      bus.flush_in = 1'b1;
      bus.inst_valid_in = 1'b1; bus.inst_in = 16'hD8A0; bus.pc_in = 16'h04FF;
      step();
      bus.flush_in = 1'b0;
      bus.inst_valid_in = 1'b0;
      checks++; if (bus.dec_valid_out !== 1'b0 || bus.count_out !== 3'd0) begin errors++; $display("[TB] FAIL flush_clear: got valid %b count %0d want 0/0", bus.dec_valid_out, bus.count_out); end
      bus.dec_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.dec_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped[%0d]: got valid %b pc %h want 0", i, bus.dec_valid_out, bus.dec_pc_out); end
      end
      bus.dec_ready_in = 1'b0;
   endtask

   task automatic test_reset_midstream();
      bus.dec_ready_in = 1'b0;
      for (int i = 0; i < 4; i++) push_one(16'hD8A0, 16'h0500 + 16'(i));
      checks++; if (bus.count_out !== 3'd3 || bus.dec_pc_out !== 16'h0500) begin errors++; $display("[TB] FAIL mid_pre: got count %0d pc %h want 3/0500", bus.count_out, bus.dec_pc_out); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.count_out !== 3'd0 || bus.dec_valid_out !== 1'b0 || bus.inst_ready_out !== 1'b1 || bus.halted_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ctrl: got count %0d valid %b ready %b halted %b want 0/0/1/0", bus.count_out, bus.dec_valid_out, bus.inst_ready_out, bus.halted_out); end
      checks++; if (bus.dec_pc_out !== 16'h0 || bus.dec_class_out !== 4'd0 || bus.dec_opcode_out !== 5'd0 || bus.dec_rt_out !== 3'd0 || bus.dec_wr_en_out !== 1'b0 || bus.dec_imm_out !== 16'h0) begin errors++; $display("[TB] FAIL mid_reset_data: got pc %h class %0d op %0d rt %0d wr %b imm %h want 0", bus.dec_pc_out, bus.dec_class_out, bus.dec_opcode_out, bus.dec_rt_out, bus.dec_wr_en_out, bus.dec_imm_out); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_one(16'h533F, 16'h0600);
      step();
      checks++; if (bus.dec_valid_out !== 1'b1 || bus.dec_pc_out !== 16'h0600 || bus.dec_imm_out !== 16'h001F) begin errors++; $display("[TB] FAIL post_reset: got valid %b pc %h imm %h want 1/0600/001F", bus.dec_valid_out, bus.dec_pc_out, bus.dec_imm_out); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      $display("[TB] decode_queue bench start");
      test_reset();
      test_add_decode();
      test_immediates();
      test_full();
      test_back_to_back();
      test_halt();
      test_flush();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
